// File: rtl/chan_input_pacer.sv
// chan_input_pacer
//   Buffers incoming I/Q samples in a small FIFO and releases them to the
//   channelizer at a fixed cadence of one sample every max(Gap_cycles,1)
//   cycles once a priming fill level has been reached.
//
// Parameters
//   DATA_WIDTH  I/Q sample width
//   FIFO_DEPTH  buffer depth (power of 2, >= 4)
//   GAP_WIDTH   width of the spacing control
//
// Ports
//   Clk, Rst            clock; synchronous active-low reset
//   Enable, Flush       run request; discard buffer and return to idle
//   Gap_cycles          output period in cycles (0 and 1 = every cycle)
//   Prime_level         fill required before output starts
//   Input_valid/ready   sample input handshake, Input_data[0]=I, [1]=Q
//   Output_valid/data   paced output, data forced to zero when not valid
//   Level               current fill
//   Error_overflow      pulse: input offered while buffer full (dropped)
//   Error_underrun      pulse: output slot found the buffer empty
//
// Optional build macro CHAN_INPUT_PACER_STATS_EN adds Stat_output_count
// (32-bit) and Stat_underrun_count (16-bit), saturating, cleared by reset only.
module chan_input_pacer #(
    parameter int DATA_WIDTH = 12,
    parameter int FIFO_DEPTH = 16,
    parameter int GAP_WIDTH  = 4,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int LW = AW + 1
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         Enable,
    input  logic                         Flush,
    input  logic [GAP_WIDTH-1:0]         Gap_cycles,
    input  logic [LW-1:0]                Prime_level,
    input  logic                         Input_valid,
    output logic                         Input_ready,
    input  logic signed [DATA_WIDTH-1:0] Input_data [2],
    output logic                         Output_valid,
    output logic signed [DATA_WIDTH-1:0] Output_data [2],
    output logic [LW-1:0]                Level,
    output logic                         Error_overflow,
    output logic                         Error_underrun
`ifdef CHAN_INPUT_PACER_STATS_EN
    ,
    output logic [31:0]                  Stat_output_count,
    output logic [15:0]                  Stat_underrun_count
`endif
);

    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t                  state, state_next;
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [GAP_WIDTH-1:0]    cnt, period;
    logic                    full, empty, push, pop, slot, underrun;
    logic signed [DATA_WIDTH-1:0] mem_i [FIFO_DEPTH];
    logic signed [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    assign full        = (Level == DEPTH_L);
    assign empty       = (Level == '0);
    assign Input_ready = Rst && !full && !Flush;
    assign push        = Input_valid && Input_ready;

    always_comb begin
        state_next = state;
        slot       = 1'b0;
        pop        = 1'b0;
        underrun   = 1'b0;
        period     = (Gap_cycles == '0) ? GAP_WIDTH'(1) : Gap_cycles;
        case (state)
            IDLE: begin
                if (Enable) state_next = PRIME;
            end
            PRIME: begin
                if (!Enable)                  state_next = IDLE;
                else if (Level >= Prime_level) state_next = RUN;
            end
            RUN: begin
                slot = (cnt == '0);
                if (slot) begin
                    if (!empty) pop      = 1'b1;
                    else        underrun = 1'b1;
                end
                // The current slot still completes; Enable low only blocks later ones.
                if (!Enable)       state_next = IDLE;
                else if (underrun) state_next = PRIME;
            end
            default: state_next = IDLE;
        endcase
        if (Flush) begin
            state_next = IDLE;
            pop        = 1'b0;
            underrun   = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            mem_i[wr_ptr] <= Input_data[0];
            mem_q[wr_ptr] <= Input_data[1];
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state          <= IDLE;
            Level          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            cnt            <= '0;
            Output_valid   <= 1'b0;
            Output_data[0] <= '0;
            Output_data[1] <= '0;
            Error_overflow <= 1'b0;
            Error_underrun <= 1'b0;
        end else begin
            state          <= state_next;
            Error_overflow <= Input_valid && full;
            Error_underrun <= underrun;
            Output_valid   <= pop;
            Output_data[0] <= pop ? mem_i[rd_ptr] : '0;
            Output_data[1] <= pop ? mem_q[rd_ptr] : '0;
            if (Flush) begin
                Level  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   Level <= Level + LW'(1);
                    2'b01:   Level <= Level - LW'(1);
                    default: Level <= Level;
                endcase
                // Counter is held at zero outside RUN so the first RUN cycle is a slot.
                if (state == RUN && state_next == RUN)
                    cnt <= slot ? (period - GAP_WIDTH'(1)) : (cnt - GAP_WIDTH'(1));
                else
                    cnt <= '0;
            end
        end
    end

`ifdef CHAN_INPUT_PACER_STATS_EN
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            Stat_output_count   <= '0;
            Stat_underrun_count <= '0;
        end else begin
            if (Output_valid && Stat_output_count != '1)
                Stat_output_count <= Stat_output_count + 32'd1;
            if (Error_underrun && Stat_underrun_count != '1)
                Stat_underrun_count <= Stat_underrun_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_chan_input_pacer.sv
// Randomized and directed bench for chan_input_pacer with a queue-based
// reference model and an output scoreboard.
module tb_chan_input_pacer;

    localparam int DW    = 12;
    localparam int DEPTH = 16;
    localparam int GW    = 4;
    localparam int LW    = 5;

    logic Clk = 1'b0;
    logic Rst, Enable, Flush, Input_valid, Input_ready;
    logic Output_valid, Error_overflow, Error_underrun;
    logic [GW-1:0] Gap_cycles;
    logic [LW-1:0] Prime_level, Level;
    logic signed [DW-1:0] Input_data [2];
    logic signed [DW-1:0] Output_data [2];
`ifdef CHAN_INPUT_PACER_STATS_EN
    logic [31:0] Stat_output_count;
    logic [15:0] Stat_underrun_count;
`endif

    always #5 Clk = ~Clk;

    chan_input_pacer #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .GAP_WIDTH (GW)
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .Enable        (Enable),
        .Flush         (Flush),
        .Gap_cycles    (Gap_cycles),
        .Prime_level   (Prime_level),
        .Input_valid   (Input_valid),
        .Input_ready   (Input_ready),
        .Input_data    (Input_data),
        .Output_valid  (Output_valid),
        .Output_data   (Output_data),
        .Level         (Level),
        .Error_overflow(Error_overflow),
        .Error_underrun(Error_underrun)
`ifdef CHAN_INPUT_PACER_STATS_EN
        ,
        .Stat_output_count  (Stat_output_count),
        .Stat_underrun_count(Stat_underrun_count)
`endif
    );

    // Reference model: sample queue, mode, and absolute cycle of the next slot.
    typedef enum {M_IDLE, M_PRIME, M_RUN} mode_t;
    mode_t            mode = M_IDLE;
    logic [2*DW-1:0]  fifo[$];
    logic [2*DW-1:0]  sb[$];
    int               cyc = 0;
    int               next_slot = 0;
    bit               exp_valid = 0, exp_ov = 0, exp_un = 0;
    longint           n_out = 0, n_un = 0;
    int               errors = 0, checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge Clk) begin : model
        bit rdy;
        int p;
        if (!Rst) begin
            fifo.delete();
            sb.delete();
            mode = M_IDLE;
            exp_valid = 0; exp_ov = 0; exp_un = 0;
            n_out = 0; n_un = 0;
        end else begin
            if (exp_valid && n_out < 64'hFFFF_FFFF) n_out++;
            if (exp_un && n_un < 64'hFFFF) n_un++;
            rdy = (fifo.size() < DEPTH) && !Flush;
            exp_ov = Input_valid && (fifo.size() == DEPTH);
            exp_valid = 0;
            exp_un = 0;
            if (Flush) begin
                fifo.delete();
                mode = M_IDLE;
            end else begin
                case (mode)
                    M_IDLE: if (Enable) mode = M_PRIME;
                    M_PRIME: begin
                        if (!Enable) mode = M_IDLE;
                        else if (fifo.size() >= int'(Prime_level)) begin
                            mode = M_RUN;
                            next_slot = cyc + 1;
                        end
                    end
                    M_RUN: begin
                        if (cyc == next_slot) begin
                            if (fifo.size() > 0) begin
                                sb.push_back(fifo.pop_front());
                                exp_valid = 1;
                                p = (Gap_cycles == 0) ? 1 : int'(Gap_cycles);
                                next_slot = cyc + p;
                            end else begin
                                exp_un = 1;
                                mode = M_PRIME;
                            end
                        end
                        if (!Enable) mode = M_IDLE;
                    end
                    default: mode = M_IDLE;
                endcase
                if (Input_valid && rdy) fifo.push_back({Input_data[1], Input_data[0]});
            end
        end
        cyc++;
    end

    always @(posedge Clk) begin : monitor
        logic [2*DW-1:0] e;
        #1;
        chk("output_valid", Output_valid, exp_valid);
        if (Output_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("output_data", {Output_data[1], Output_data[0]}, e);
            end
        end else begin
            chk("idle_data_zero", {Output_data[1], Output_data[0]}, 0);
        end
        chk("level", Level, fifo.size());
        chk("overflow", Error_overflow, exp_ov);
        chk("underrun", Error_underrun, exp_un);
        chk("input_ready", Input_ready, Rst && (fifo.size() < DEPTH) && !Flush);
`ifdef CHAN_INPUT_PACER_STATS_EN
        chk("stat_output", Stat_output_count, n_out);
        chk("stat_underrun", Stat_underrun_count, n_un);
`endif
    end

    task automatic set_sample();
        Input_data[0] = $signed(DW'($urandom));
        Input_data[1] = $signed(DW'($urandom));
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) begin
            Input_valid = 1'b1;
            set_sample();
            @(negedge Clk);
        end
        Input_valid = 1'b0;
    endtask

    task automatic flush_pulse();
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
    endtask

    initial begin
        Rst = 1'b0; Enable = 1'b0; Flush = 1'b0; Input_valid = 1'b0;
        Gap_cycles = 4'd4; Prime_level = 5'd4;
        Input_data[0] = '0; Input_data[1] = '0;
        repeat (2) @(negedge Clk);
        Rst = 1'b1;

        // Eight samples then paced drain at period 4
        push_n(8);
        Enable = 1'b1;
        repeat (40) @(negedge Clk);
        Enable = 1'b0;
        @(negedge Clk);

        // Two samples, prime 2: two outputs then underrun back to PRIME
        flush_pulse();
        Gap_cycles = 4'd4;
        push_n(2);
        Prime_level = 5'd2;
        Enable = 1'b1;
        repeat (20) @(negedge Clk);
        Enable = 1'b0;
        @(negedge Clk);

        // Overfill while idle: 17th sample dropped with one overflow pulse
        flush_pulse();
        push_n(17);
        repeat (2) @(negedge Clk);

        // Gap 0 with full buffer: back-to-back outputs
        Gap_cycles = 4'd0;
        Prime_level = 5'd16;
        Enable = 1'b1;
        repeat (24) @(negedge Clk);
        Enable = 1'b0;
        @(negedge Clk);

        // Flush with concurrent input while running at level 10
        flush_pulse();
        Gap_cycles = 4'd15;
        push_n(11);
        Prime_level = 5'd11;
        Enable = 1'b1;
        repeat (4) @(negedge Clk);
        Flush = 1'b1;
        Input_valid = 1'b1;
        set_sample();
        @(negedge Clk);
        Flush = 1'b0;
        Input_valid = 1'b0;
        Enable = 1'b0;
        repeat (3) @(negedge Clk);

        // Reset while running at level 5
        Gap_cycles = 4'd8;
        Prime_level = 5'd6;
        push_n(6);
        Enable = 1'b1;
        repeat (4) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        Enable = 1'b0;
        repeat (3) @(negedge Clk);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            Rst   = ($urandom_range(0, 199) != 0);
            Flush = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 24) == 0) Enable = ~Enable;
            if ($urandom_range(0, 29) == 0) Gap_cycles = GW'($urandom_range(0, 5));
            if ($urandom_range(0, 39) == 0) Prime_level = LW'($urandom_range(0, 17));
            Input_valid = (((i / 100) % 2) == 0) ? ($urandom_range(0, 3) != 0)
                                                 : ($urandom_range(0, 3) == 0);
            set_sample();
            @(negedge Clk);
        end
        Rst = 1'b1; Flush = 1'b0; Input_valid = 1'b0; Enable = 1'b0;
        repeat (3) @(negedge Clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/chan_input_pacer.md
CHAN_INPUT_PACER -- requirements
Module: chan_input_pacer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, meaning I/Q sample width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning sample buffer depth; power of 2, at least 4.
REQ-003 SHALL have parameter GAP_WIDTH, default 4, meaning width of the spacing control.
REQ-004 SHALL have ports: Clk in 1, clock; Rst in 1, reset, synchronous, active-low.
REQ-005 SHALL have ports: Enable in 1, pacing run request; Flush in 1, discard buffer and return to IDLE.
REQ-006 SHALL have ports: Gap_cycles in GAP_WIDTH, output period in cycles (0 and 1 both mean every cycle); Prime_level in $clog2(FIFO_DEPTH)+1, fill needed to start.
REQ-007 SHALL have ports: Input_valid in 1; Input_ready out 1; Input_data in signed DATA_WIDTH x2 (index 0 = I, 1 = Q).
REQ-008 SHALL have ports: Output_valid out 1; Output_data out signed DATA_WIDTH x2, feeding the channelizer input.
REQ-009 SHALL have ports: Level out $clog2(FIFO_DEPTH)+1, current fill; Error_overflow out 1 pulse; Error_underrun out 1 pulse.

Function
REQ-010 SHALL accept an input sample when Input_valid && Input_ready; Input_ready = (Level < FIFO_DEPTH) && !Flush.
REQ-011 SHALL assert Error_overflow for one cycle when Input_valid is high while Level == FIFO_DEPTH; the sample is dropped.
REQ-012 SHALL implement states IDLE, PRIME, RUN.
REQ-013 IDLE: no output; go to PRIME when Enable = 1.
REQ-014 PRIME: no output; go to RUN when Level >= Prime_level (Prime_level = 0 means immediately); go to IDLE if Enable = 0.
REQ-015 RUN: period counter runs modulo max(Gap_cycles,1); each time it reaches 0 a slot occurs.
REQ-016 At a slot with Level > 0, SHALL pop one sample and drive Output_valid = 1 with it on the next cycle (one-cycle registered latency).
REQ-017 At a slot with Level = 0, SHALL pulse Error_underrun, not assert Output_valid, and go to PRIME.
REQ-018 The first slot SHALL occur on the first RUN cycle; consecutive Output_valid pulses SHALL be exactly max(Gap_cycles,1) cycles apart while the buffer is non-empty.
REQ-019 Output_data SHALL be zero whenever Output_valid = 0.
REQ-020 Enable deassertion in RUN SHALL take effect after the current cycle: no further slots, state IDLE, buffer contents retained.
REQ-021 Simultaneous push and pop SHALL leave Level unchanged, including at Level = FIFO_DEPTH (Input_ready low there, so no push) and Level = 0 (pop not allowed).
REQ-022 Flush SHALL, on the next cycle, set Level to 0, state to IDLE, and clear the period counter; Flush overrides push, pop, and Enable in the same cycle.
REQ-023 Gap_cycles SHALL be sampled at each slot; a change takes effect from the next period.
REQ-024 Read/write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-025 With Rst = 0 at a clock edge: state IDLE, Level 0, pointers 0, counter 0, Output_valid 0, Output_data 0, Error_overflow 0, Error_underrun 0; Input_ready SHALL read 0 while Rst = 0.
REQ-026 Reset mid-RUN SHALL discard buffered samples; no Output_valid in the cycle following the reset edge.

Configuration
REQ-027 When macro CHAN_INPUT_PACER_STATS_EN is defined, SHALL add outputs Stat_output_count (32-bit) and Stat_underrun_count (16-bit).
REQ-028 The stat counters increment on each Output_valid and each Error_underrun respectively, saturate, and clear on reset only (not on Flush).
REQ-029 When CHAN_INPUT_PACER_STATS_EN is undefined, these ports and counters SHALL not exist, and all other behaviour SHALL be identical.

Verification
REQ-030 Gap_cycles=4, Prime_level=4; push 8 samples back-to-back, then Enable -> 8 Output_valid pulses spaced 4 cycles apart, in input order, with no errors.
REQ-031 Gap_cycles=4; push 2 samples, Prime_level=2, Enable, no more input -> 2 outputs, then one Error_underrun pulse at the third slot, state PRIME.
REQ-032 FIFO_DEPTH=16, Enable=0; push 17 samples -> Input_ready low after the 16th, Level=16, and one Error_overflow pulse if the 17th is held valid for one cycle.
REQ-033 In RUN with Level=10, assert Flush together with Input_valid -> next cycle Level=0, state IDLE, no output; that input is not accepted.
REQ-034 Gap_cycles=0 with a full FIFO -> 16 consecutive Output_valid cycles.
REQ-035 Rst=0 for one cycle in RUN with Level=5 -> all outputs 0, Level 0; with STATS_EN defined, counters read 0.
